// File: rtl/vector_sequencer_if.sv
// rtl/vector_sequencer_if.sv - bus-side signals between the vector sequencer and the shared datapath
//
// Purpose: groups the address-bus mux / data-bus buffer signals driven by the
// interrupt entry sequencer.
// Signals:
//   addr     16  address presented to the bus mux
//   addr_sel  1  1 = sequencer owns the address bus
//   rw        1  1 = read, 0 = write
//   wdata     8  write data to the data-bus buffer
//   data_in   8  read data returned from the pins
interface vector_sequencer_if;
  logic [15:0] addr;
  logic        addr_sel;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  data_in;

  modport master (output addr, addr_sel, rw, wdata, input data_in);
  modport slave  (input addr, addr_sel, rw, wdata, output data_in);
endinterface

// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - 6502 reset/NMI/IRQ/BRK entry sequencer on the shared datapath
//
// Purpose: runs two dummy reads, pushes PCH/PCL/P, fetches the vector and
// loads PC. One state per step_en strobe; all outputs are registered.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   step_en           datapath phase strobe (state advances only when 1)
//   instr_boundary    decode is at an opcode fetch; interrupts may be taken
//   irq, nmi, brk_req interrupt sources (irq level, nmi rising edge)
//   i_flag            IRQ mask
//   pc_in, sp_in,p_in current PC, stack pointer, status byte
//   bus               address/data bus signals (master side)
//   busy              sequence in progress; decode stalls
//   sp_dec            pulse: decrement SP
//   pc_load,pc_value  pulse + value: load new PC
//   set_i             pulse: set I flag
//   nmi_ack           pulse: an NMI vector was taken
module vector_sequencer #(
  parameter logic [15:0] RESET_VEC  = 16'hFFFC,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_en,
  input  logic                instr_boundary,
  input  logic                irq,
  input  logic                nmi,
  input  logic                brk_req,
  input  logic                i_flag,
  input  logic [15:0]         pc_in,
  input  logic [7:0]          sp_in,
  input  logic [7:0]          p_in,
  vector_sequencer_if.master  bus,
  output logic                busy,
  output logic                sp_dec,
  output logic                pc_load,
  output logic [15:0]         pc_value,
  output logic                set_i,
  output logic                nmi_ack
);

  typedef enum logic [2:0] {IDLE, DUM1, DUM2, PSH_H, PSH_L, PSH_P, VEC_L, VEC_H} state_t;
  typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

  state_t      state, state_d;
  src_t        src, src_d;
  logic [15:0] vec, vec_d;
  logic [7:0]  vec_lo, vec_lo_d;
  logic        reset_pend, reset_pend_d;
  logic        nmi_prev, nmi_lat, nmi_edge;

  logic [15:0] addr_d, pc_value_d;
  logic [7:0]  wdata_d, p_push;
  logic        addr_sel_d, rw_d, sp_dec_d, pc_load_d, set_i_d, nmi_ack_d;

  assign nmi_edge = nmi & ~nmi_prev;

  // Pushed status: bit5 forced to 1, bit4 (B) marks a software BRK.
  assign p_push = (p_in & 8'hEF) | 8'h20 | {3'b000, (src == SRC_BRK), 4'b0000};

  // Bus outputs are registered from the current state each clock, so they
  // settle one clock after a state is entered. The phase strobe arrives at
  // most every other clock, which leaves the bus (and sp_in after an sp_dec)
  // stable before the step edge that consumes it.
  always_comb begin
    state_d      = state;
    src_d        = src;
    vec_d        = vec;
    vec_lo_d     = vec_lo;
    reset_pend_d = reset_pend;
    addr_d       = 16'h0000;
    addr_sel_d   = 1'b0;
    rw_d         = 1'b1;
    wdata_d      = 8'h00;
    sp_dec_d     = 1'b0;
    pc_load_d    = 1'b0;
    set_i_d      = 1'b0;
    nmi_ack_d    = 1'b0;
    pc_value_d   = pc_value;

    unique case (state)
      IDLE: begin
        if (step_en) begin
          if (reset_pend) begin
            src_d   = SRC_RESET;
            vec_d   = RESET_VEC;
            state_d = DUM1;
          end else if (instr_boundary) begin
            if (nmi_lat) begin
              src_d   = SRC_NMI;
              vec_d   = NMI_VEC;
              state_d = DUM1;
            end else if (irq && !i_flag) begin
              src_d   = SRC_IRQ;
              vec_d   = IRQ_VEC;
              state_d = DUM1;
            end else if (brk_req) begin
              src_d   = SRC_BRK;
              vec_d   = IRQ_VEC;
              state_d = DUM1;
            end
          end
        end
      end
      DUM1: begin
        addr_d     = pc_in;
        addr_sel_d = 1'b1;
        if (step_en) state_d = DUM2;
      end
      DUM2: begin
        addr_d     = pc_in;
        addr_sel_d = 1'b1;
        if (step_en) state_d = PSH_H;
      end
      PSH_H, PSH_L, PSH_P: begin
        addr_d     = {STACK_PAGE, sp_in};
        addr_sel_d = 1'b1;
        // A reset sequence walks the stack but never writes it.
        rw_d       = (src == SRC_RESET);
        wdata_d    = (state == PSH_H) ? pc_in[15:8] :
                     (state == PSH_L) ? pc_in[7:0]  : p_push;
        if (step_en) begin
          sp_dec_d = 1'b1;
          state_d  = (state == PSH_H) ? PSH_L :
                     (state == PSH_L) ? PSH_P : VEC_L;
        end
      end
      VEC_L: begin
        addr_d     = vec;
        addr_sel_d = 1'b1;
        if (step_en) begin
          vec_lo_d = bus.data_in;
          state_d  = VEC_H;
        end
      end
      VEC_H: begin
        addr_d     = vec + 16'd1;
        addr_sel_d = 1'b1;
        if (step_en) begin
          pc_value_d = {bus.data_in, vec_lo};
          pc_load_d  = 1'b1;
          set_i_d    = 1'b1;
          nmi_ack_d  = (vec == NMI_VEC);
          if (src == SRC_RESET) reset_pend_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // NMI hijack: a latched NMI redirects an IRQ/BRK sequence as long as the
    // vector fetch has not started; B in the pushed P is left as it was.
    if (nmi_lat && (src == SRC_IRQ || src == SRC_BRK) &&
        (state inside {DUM1, DUM2, PSH_H, PSH_L, PSH_P}))
      vec_d = NMI_VEC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      src          <= SRC_RESET;
      vec          <= RESET_VEC;
      vec_lo       <= 8'h00;
      reset_pend   <= 1'b1;
      nmi_prev     <= 1'b0;
      nmi_lat      <= 1'b0;
      busy         <= 1'b0;
      bus.addr     <= 16'h0000;
      bus.addr_sel <= 1'b0;
      bus.rw       <= 1'b1;
      bus.wdata    <= 8'h00;
      sp_dec       <= 1'b0;
      pc_load      <= 1'b0;
      pc_value     <= 16'h0000;
      set_i        <= 1'b0;
      nmi_ack      <= 1'b0;
    end else begin
      state        <= state_d;
      src          <= src_d;
      vec          <= vec_d;
      vec_lo       <= vec_lo_d;
      reset_pend   <= reset_pend_d;
      nmi_prev     <= nmi;
      // A new edge in the acknowledging clock keeps the latch set.
      nmi_lat      <= nmi_edge | (nmi_lat & ~nmi_ack_d);
      busy         <= (state_d != IDLE);
      bus.addr     <= addr_d;
      bus.addr_sel <= addr_sel_d;
      bus.rw       <= rw_d;
      bus.wdata    <= wdata_d;
      sp_dec       <= sp_dec_d;
      pc_load      <= pc_load_d;
      pc_value     <= pc_value_d;
      set_i        <= set_i_d;
      nmi_ack      <= nmi_ack_d;
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - self-checking bench for vector_sequencer
module tb_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, step_en, instr_boundary, irq, nmi, brk_req, i_flag;
  logic [15:0] pc_in;
  logic [7:0]  sp_in, p_in;
  logic        busy, sp_dec, pc_load, set_i, nmi_ack;
  logic [15:0] pc_value;

  vector_sequencer_if bus ();

  vector_sequencer dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .instr_boundary(instr_boundary),
    .irq(irq), .nmi(nmi), .brk_req(brk_req), .i_flag(i_flag),
    .pc_in(pc_in), .sp_in(sp_in), .p_in(p_in), .bus(bus),
    .busy(busy), .sp_dec(sp_dec), .pc_load(pc_load), .pc_value(pc_value),
    .set_i(set_i), .nmi_ack(nmi_ack)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] V_RST = 16'hFFFC, V_NMI = 16'hFFFA, V_IRQ = 16'hFFFE;

  int checks = 0;
  int failures = 0;
  int gap = 0;

  typedef struct {
    logic [15:0] addr;
    logic        rw, sel;
    logic [7:0]  wdata;
    logic        sp_dec, pc_load, set_i, nmi_ack, busy;
  } obs_t;

  typedef struct {
    logic        irq, brk, ifl, nmi_e;
    logic [15:0] pc;
    logic [7:0]  sp, p;
    logic        e_busy;
    logic [15:0] e_vec;
    logic [7:0]  e_p;
    logic        e_ack;
  } tv_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory seen on the pins: vectors at the top of the map, a pattern elsewhere.
  function automatic logic [7:0] mem(input logic [15:0] a);
    case (a)
      16'hFFFA: mem = 8'h11;
      16'hFFFB: mem = 8'h90;
      16'hFFFC: mem = 8'h00;
      16'hFFFD: mem = 8'h80;
      16'hFFFE: mem = 8'h22;
      16'hFFFF: mem = 8'hA0;
      default:  mem = a[7:0] ^ a[15:8];
    endcase
  endfunction

  // One clock; the bench plays the stack pointer and the memory.
  task automatic clk1;
    @(posedge clk);
    #1;
    if (sp_dec) sp_in = sp_in - 8'd1;
    bus.data_in = mem(bus.addr);
  endtask

  // One idle clock (plus optional extra gap), sample the bus, then one strobed clock.
  task automatic step(output obs_t o, input bit inj_idle, input bit inj_step);
    step_en = 1'b0;
    if (inj_idle) nmi = 1'b1;
    clk1;
    nmi = 1'b0;
    repeat (gap) clk1;
    o.addr  = bus.addr;
    o.rw    = bus.rw;
    o.sel   = bus.addr_sel;
    o.wdata = bus.wdata;
    step_en = 1'b1;
    if (inj_step) nmi = 1'b1;
    clk1;
    step_en = 1'b0;
    nmi = 1'b0;
    o.sp_dec  = sp_dec;
    o.pc_load = pc_load;
    o.set_i   = set_i;
    o.nmi_ack = nmi_ack;
    o.busy    = busy;
  endtask

  task automatic pulse_nmi;
    nmi = 1'b1;
    clk1;
    nmi = 1'b0;
  endtask

  // Expected bus trace of an entry sequence: two reads at PC, three pushes
  // walking down the stack page, then vector low/high reads.
  task automatic run_seq(input string tag, input bit exp_busy, input bit is_rst,
                         input logic [15:0] exp_vec, input logic [7:0] exp_p,
                         input int inj_k, input bit inj_at_step, input bit exp_ack);
    obs_t        o;
    logic [15:0] pc0, ea, vec_hi, exp_pc;
    logic [7:0]  sp0, s_exp, ew;
    logic        erw, push;
    pc0 = pc_in;
    sp0 = sp_in;
    vec_hi = exp_vec + 16'd1;
    exp_pc = {mem(vec_hi), mem(exp_vec)};
    instr_boundary = !is_rst;
    step(o, 1'b0, 1'b0);
    instr_boundary = 1'b0;
    chk($sformatf("%s busy_start", tag), o.busy, exp_busy);
    if (!exp_busy) begin
      chk($sformatf("%s idle_sel", tag), bus.addr_sel, 1'b0);
    end else begin
      for (int k = 0; k < 7; k++) begin
        step(o, (k == inj_k) && !inj_at_step, (k == inj_k) && inj_at_step);
        push = (k >= 2) && (k <= 4);
        ew = 8'h00;
        case (k)
          0, 1: ea = pc0;
          2: begin ea = {8'h01, sp0}; ew = pc0[15:8]; end
          3: begin s_exp = sp0 - 8'd1; ea = {8'h01, s_exp}; ew = pc0[7:0]; end
          4: begin s_exp = sp0 - 8'd2; ea = {8'h01, s_exp}; ew = exp_p; end
          5: ea = exp_vec;
          default: ea = vec_hi;
        endcase
        erw = !push || is_rst;
        chk($sformatf("%s k%0d addr", tag, k), o.addr, ea);
        chk($sformatf("%s k%0d rw", tag, k), o.rw, erw);
        chk($sformatf("%s k%0d sel", tag, k), o.sel, 1'b1);
        if (push) chk($sformatf("%s k%0d wdata", tag, k), o.wdata, ew);
        chk($sformatf("%s k%0d sp_dec", tag, k), o.sp_dec, push);
        chk($sformatf("%s k%0d pc_load", tag, k), o.pc_load, k == 6);
        chk($sformatf("%s k%0d set_i", tag, k), o.set_i, k == 6);
        chk($sformatf("%s k%0d nmi_ack", tag, k), o.nmi_ack, (k == 6) && exp_ack);
        chk($sformatf("%s k%0d busy", tag, k), o.busy, k < 6);
      end
      chk($sformatf("%s pc_value", tag), pc_value, exp_pc);
      s_exp = sp0 - 8'd3;
      chk($sformatf("%s sp_final", tag), sp_in, s_exp);
    end
  endtask

  function automatic logic [7:0] pushed_p(input logic [7:0] p, input bit is_brk);
    logic [7:0] r;
    r = p;
    r[5] = 1'b1;
    r[4] = is_brk;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t  tv[9];
    obs_t o;
    bit   pend_nmi, fire, nmi_now, start, is_brk, inj, late;
    int   k;
    logic [15:0] ev;
    logic [7:0]  ep;
    logic        eack;

    rst_n = 1'b0; step_en = 1'b0; instr_boundary = 1'b0; irq = 1'b0; nmi = 1'b0;
    brk_req = 1'b0; i_flag = 1'b0; pc_in = 16'h0000; sp_in = 8'h00; p_in = 8'h20;
    bus.data_in = 8'h00;
    repeat (3) clk1;
    chk("rst busy", busy, 1'b0);
    chk("rst addr", bus.addr, 16'h0000);
    chk("rst sel", bus.addr_sel, 1'b0);
    chk("rst rw", bus.rw, 1'b1);
    chk("rst wdata", bus.wdata, 8'h00);
    chk("rst sp_dec", sp_dec, 1'b0);
    chk("rst pc_load", pc_load, 1'b0);
    chk("rst pc_value", pc_value, 16'h0000);
    chk("rst set_i", set_i, 1'b0);
    chk("rst nmi_ack", nmi_ack, 1'b0);

    // Reset sequence after release, no instruction boundary needed.
    rst_n = 1'b1;
    pc_in = 16'h1234; sp_in = 8'h00; p_in = 8'h20;
    run_seq("reset", 1'b1, 1'b1, V_RST, 8'h20, -1, 1'b0, 1'b0);

    //           irq brk ifl nmi  pc        sp     p      busy vec    P      ack
    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hC123, 8'hFF, 8'h20, 1'b1, V_IRQ, 8'h20, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 8'h80, 8'h20, 1'b1, V_IRQ, 8'h30, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h5555, 8'h40, 8'h24, 1'b0, V_IRQ, 8'h00, 1'b0};
    tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h2222, 8'h10, 8'h20, 1'b1, V_NMI, 8'h20, 1'b1};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h3333, 8'h02, 8'h24, 1'b1, V_IRQ, 8'h34, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 8'h00, 8'hFF, 1'b1, V_IRQ, 8'hEF, 1'b0};
    tv[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 8'h01, 8'hCF, 1'b1, V_IRQ, 8'hFF, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 8'h33, 8'h20, 1'b0, V_IRQ, 8'h00, 1'b0};
    tv[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 8'hC0, 8'h10, 1'b1, V_NMI, 8'h20, 1'b1};

    for (int i = 0; i < 9; i++) begin
      irq = tv[i].irq; brk_req = tv[i].brk; i_flag = tv[i].ifl;
      pc_in = tv[i].pc; sp_in = tv[i].sp; p_in = tv[i].p;
      if (tv[i].nmi_e) pulse_nmi();
      run_seq($sformatf("tv%0d", i), tv[i].e_busy, 1'b0, tv[i].e_vec, tv[i].e_p, -1, 1'b0, tv[i].e_ack);
      irq = 1'b0; brk_req = 1'b0;
    end

    // NMI during IRQ pushes redirects the vector; the latch is consumed.
    i_flag = 1'b0; irq = 1'b1; pc_in = 16'hC123; sp_in = 8'hFF; p_in = 8'h20;
    run_seq("hijack", 1'b1, 1'b0, V_NMI, 8'h20, 3, 1'b0, 1'b1);
    irq = 1'b0;
    run_seq("hijack_done", 1'b0, 1'b0, V_IRQ, 8'h00, -1, 1'b0, 1'b0);

    // NMI during vector fetch stays pending for the next boundary.
    brk_req = 1'b1; pc_in = 16'hABCD; sp_in = 8'h50;
    run_seq("late_nmi_vl", 1'b1, 1'b0, V_IRQ, 8'h30, 5, 1'b0, 1'b0);
    brk_req = 1'b0;
    run_seq("late_nmi_vl_next", 1'b1, 1'b0, V_NMI, 8'h20, -1, 1'b0, 1'b1);
    irq = 1'b1;
    run_seq("late_nmi_vh", 1'b1, 1'b0, V_IRQ, 8'h20, 6, 1'b0, 1'b0);
    irq = 1'b0;
    run_seq("late_nmi_vh_next", 1'b1, 1'b0, V_NMI, 8'h20, -1, 1'b0, 1'b1);

    // Edge in the acknowledging clock re-arms the latch.
    pulse_nmi();
    run_seq("ack_edge", 1'b1, 1'b0, V_NMI, 8'h20, 6, 1'b1, 1'b1);
    run_seq("ack_edge_next", 1'b1, 1'b0, V_NMI, 8'h20, -1, 1'b0, 1'b1);
    run_seq("ack_edge_idle", 1'b0, 1'b0, V_IRQ, 8'h00, -1, 1'b0, 1'b0);

    // Reset in the middle of an IRQ sequence.
    irq = 1'b1; instr_boundary = 1'b1;
    step(o, 1'b0, 1'b0);
    instr_boundary = 1'b0; irq = 1'b0;
    chk("midrst started", o.busy, 1'b1);
    for (int j = 0; j < 4; j++) step(o, 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step_en = j[0];
      clk1;
      chk($sformatf("midrst c%0d pc_load", j), pc_load, 1'b0);
      chk($sformatf("midrst c%0d busy", j), busy, 1'b0);
      chk($sformatf("midrst c%0d sel", j), bus.addr_sel, 1'b0);
      chk($sformatf("midrst c%0d rw", j), bus.rw, 1'b1);
      chk($sformatf("midrst c%0d sp_dec", j), sp_dec, 1'b0);
      chk($sformatf("midrst c%0d pc_value", j), pc_value, 16'h0000);
    end
    step_en = 1'b0;
    rst_n = 1'b1;
    pc_in = 16'h0F0F; sp_in = 8'hFD; p_in = 8'hFF;
    run_seq("midrst_reset", 1'b1, 1'b1, V_RST, 8'hEF, -1, 1'b0, 1'b0);

    // Randomised boundaries checked against the priority rules.
    pend_nmi = 1'b0;
    for (int it = 0; it < 60; it++) begin
      gap = $urandom_range(0, 2);
      irq = 1'($urandom_range(0, 1)); brk_req = 1'($urandom_range(0, 1));
      i_flag = 1'($urandom_range(0, 1));
      pc_in = 16'($urandom); sp_in = 8'($urandom); p_in = 8'($urandom);
      fire = !pend_nmi && ($urandom_range(0, 3) == 0);
      if (fire) pulse_nmi();
      nmi_now = pend_nmi || fire;
      is_brk = 1'b0; start = 1'b1; eack = 1'b0; ev = V_IRQ;
      if (nmi_now) begin
        ev = V_NMI; eack = 1'b1;
      end else if (irq && !i_flag) begin
        ev = V_IRQ;
      end else if (brk_req) begin
        ev = V_IRQ; is_brk = 1'b1;
      end else begin
        start = 1'b0;
      end
      ep = pushed_p(p_in, is_brk);
      inj = start && !nmi_now && ($urandom_range(0, 2) == 0);
      k = inj ? int'($urandom_range(0, 6)) : -1;
      late = inj && (k >= 5);
      if (inj && !late) begin
        ev = V_NMI; eack = 1'b1;
      end
      run_seq($sformatf("rnd%0d", it), start, 1'b0, ev, ep, k, 1'b0, eack);
      pend_nmi = late;
      irq = 1'b0; brk_req = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Controller that runs the 6502 interrupt/reset entry sequence on the shared datapath: two dummy cycles, stack pushes of PCH/PCL/P, vector fetch, PC load.
- Sits between interrupt_logic / instruction_decode and the address-bus mux, data-bus buffer, PC and stack pointer.
- Arbitrates four sources: reset, NMI, IRQ, BRK.
- Advances one state per datapath phase strobe, so it stays aligned with the two-phase multiplexed pin bus.

Parameters:
- RESET_VEC, 16'hFFFC, address of reset vector low byte.
- NMI_VEC, 16'hFFFA, address of NMI vector low byte.
- IRQ_VEC, 16'hFFFE, address of IRQ/BRK vector low byte.
- STACK_PAGE, 8'h01, high byte of stack addresses.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- step_en  in  1  phase strobe; state advances only on clk edges with step_en=1
- instr_boundary  in  1  decode is at an opcode-fetch boundary; interrupts may be taken
- irq  in  1  level IRQ request
- nmi  in  1  NMI request, rising-edge sensitive
- brk_req  in  1  decode executing BRK, sampled at boundary
- i_flag  in  1  interrupt-disable flag
- pc_in  in  16  current PC
- sp_in  in  8  current stack pointer
- p_in  in  8  current status byte (bit4 = B, bit5 = 1)
- data_in  in  8  read data from pins
- busy  out  1  sequence active; decode must stall
- addr  out  16  address to bus mux
- addr_sel  out  1  1 = drive addr onto address bus
- rw  out  1  1 = read, 0 = write
- wdata  out  8  write data to data-bus buffer
- sp_dec  out  1  one-clock pulse: decrement SP
- pc_load  out  1  one-clock pulse: load pc_value into PC
- pc_value  out  16  new PC
- set_i  out  1  one-clock pulse: set I flag
- nmi_ack  out  1  one-clock pulse when an NMI sequence commits its vector

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous, active-low.
- While rst_n=0 (all outputs registered):
  - state=IDLE, busy=0, addr=0, addr_sel=0, rw=1, wdata=0.
  - All pulses 0, pc_value=0, nmi edge latch cleared, nmi_prev=0.
  - reset_pend=1.
- States: IDLE, DUM1, DUM2, PSH_H, PSH_L, PSH_P, VEC_L, VEC_H. All transitions occur only on step_en=1.
- Start from IDLE:
  - reset_pend=1 starts a RESET sequence without waiting for instr_boundary.
  - Otherwise, when instr_boundary=1, priority is NMI latch > (irq & ~i_flag) > brk_req.
  - Source is latched in src; busy=1 from the next clock until the clock after VEC_H completes.
- DUM1/DUM2: addr=pc_in, rw=1.
- PSH_H, PSH_L, PSH_P:
  - addr={STACK_PAGE, sp_in}.
  - wdata = pc_in[15:8], pc_in[7:0], then P.
  - P = p_in with bit5=1 and bit4 = (src==BRK).
  - sp_dec pulses on each step.
  - rw=0, except src==RESET forces rw=1 (suppressed writes); SP still decrements, 3 total.
- VEC_L: addr=vector; data_in captured into vec_lo on step.
- VEC_H: addr=vector+1. On step:
  - pc_value={data_in, vec_lo}; pc_load=1 and set_i=1 for that clock.
  - nmi_ack=1 if the final vector was NMI_VEC.
  - Return to IDLE; reset_pend cleared for RESET.
- Total: 7 steps per sequence; pc_load occurs on the 7th step.
- NMI edge detect:
  - nmi_prev updates every clk.
  - A rising edge sets the latch. The latch clears when nmi_ack pulses.
  - An edge in the same clock as the ack re-sets the latch (set wins).
- NMI hijack: an NMI latched during an IRQ/BRK sequence before the VEC_L step switches the vector to NMI_VEC; the pushed B bit is unchanged. Latched at/after VEC_L: stays pending for the next boundary.
- IRQ deasserted mid-sequence: the sequence completes anyway.
- Boundaries:
  - i_flag=1 masks IRQ only; NMI, BRK and RESET are unaffected.
  - SP wraps mod 256; this block only pulses sp_dec.
  - vector+1 computed in 16 bits; no page-carry special case.
- rst_n low mid-sequence: immediate return to reset values, no further pulses; after release, a RESET sequence runs.

Test Plan:
- Release rst_n, step_en every other clock, pc_in=16'h1234, sp_in=8'h00, data_in=8'h00 at FFFC and 8'h80 at FFFD -> rw=1 all 7 steps, 3 sp_dec pulses, pc_load with pc_value=16'h8000, set_i=1, nmi_ack=0.
- IRQ at boundary: i_flag=0, pc_in=16'hC123, sp_in=8'hFF, p_in=8'h20 -> writes C1@01FF, 23@01FE (sp_in updated by bench), 20@01FD, then reads FFFE/FFFF.
- BRK with p_in=8'h20 -> pushed P=8'h30. IRQ with i_flag=1 and no other source -> busy stays 0.
- NMI rising edge during IRQ sequence at PSH_L -> vector addr FFFA/FFFB, nmi_ack pulses once. NMI edge at VEC_H -> second sequence starts at the next boundary.
- NMI, irq=1 and brk_req=1 simultaneous at boundary -> NMI served first. Next boundary with i_flag=1 -> BRK served with vector FFFE and P bit4=1.
- rst_n low at PSH_P of an IRQ sequence -> no pc_load, outputs at reset values. After release -> full RESET sequence.
